regfile_wb_queue: RTL and testbench
===================================

# regfile_wb_queue

Writeback queue that sits between the execute/memory stages and the 16x16 register file write port. It accepts register results from two producers (ALU and memory) with valid/ready handshakes and buffers them in a FIFO. It drains one entry per cycle into the register file's DstReg/WriteReg/DstData port. It also publishes a per-register pending-write scoreboard so decode can stall on RAW hazards, plus an optional bypass lookup.

## Interface
- DEPTH, 4, queue entries (power of two, >= 2)
- DATA_W, 16, register data width
- REG_W, 4, register index width (2^REG_W registers)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  memory producer has a result
- mem_dst  in  REG_W  destination register
- mem_data  in  DATA_W  result value
- mem_ready  out  1  queue accepts memory result this cycle
- alu_valid  in  1  ALU producer has a result
- alu_dst  in  REG_W  destination register
- alu_data  in  DATA_W  result value
- alu_ready  out  1  queue accepts ALU result this cycle
- rf_we  out  1  to register file WriteReg
- rf_dst  out  REG_W  to register file DstReg
- rf_data  out  DATA_W  to register file DstData
- pending  out  2^REG_W  bit i = write to register i outstanding
- byp_reg  in  REG_W  bypass lookup register
- byp_hit  out  1  bypass hit
- byp_data  out  DATA_W  bypass value

## Operation
- Storage: circular FIFO of DEPTH entries {dst, data}, with head/tail pointers and a count register of width clog2(DEPTH)+1.
- Handshake: a transfer occurs when valid && ready in the same cycle. Ready depends only on the start-of-cycle count (and mem_valid for ALU), never on its own valid.
  - mem_ready = !rst && count <= DEPTH-1.
  - alu_ready = !rst && (count <= DEPTH-2 || (count == DEPTH-1 && !mem_valid)).
- Ordering: the memory result is older than the ALU result.
  - When both transfer in one cycle, the memory result is enqueued first and the ALU result second.
  - When both target the same register, the ALU value is the final one.
- Register 0: a transfer with dst == 0 completes the handshake but stores nothing, and count is not incremented for it.
- Drain: while count > 0, rf_we = 1, rf_dst = head.dst, rf_data = head.data. The head pops every cycle, since the register file always accepts.
- Empty queue: rf_we = 0, rf_dst = 0, rf_data = 0.
- Count update: count_next = count + pushes - pop, where pushes is 0..2 and pop is 0..1. Push and pop in the same cycle are legal, including at count == DEPTH with a pop. The ready rules guarantee count never exceeds DEPTH.
- pending[i] = 1 iff any valid entry has dst == i. pending[0] is always 0. pending is computed from stored entries only; inputs being enqueued this cycle are excluded.
- FIFO order is preserved end to end, so later writes to the same register land later.

## Timing
- Reset (rst sampled high at an edge): after that edge, count = 0, pointers = 0, rf_we = 0, rf_dst = 0, rf_data = 0, pending = 0, byp_hit = 0, byp_data = 0.
- mem_ready and alu_ready are 0 while rst is high, and 1 in the first cycle after rst is released.
- Reset mid-operation flushes all entries. Flushed results are never written.
- Latency: a result enqueued at edge N into an empty queue presents rf_we = 1 during cycle N..N+1 and is written into the register file at edge N+1.
- Dual enqueue into an empty queue: memory result written at N+1, ALU result at N+2.
- pending bit rises in the cycle after the enqueue edge. It falls in the cycle after the last matching entry's write edge.
- Full: count == DEPTH drives both readies to 0 for that cycle. They recover in the cycle after a pop.

## Configuration
- WB_BYPASS_EN defined:
  - byp_hit = 1 iff any valid entry has dst == byp_reg and byp_reg != 0.
  - byp_data = data of the youngest matching entry, or 0 on a miss.
  - Purely combinational from stored entries and byp_reg.
- WB_BYPASS_EN undefined:
  - byp_reg is ignored.
  - byp_hit = 0 and byp_data = 0 constantly.
  - The ports remain present.

## Test plan
- Reset then single ALU write: alu_valid=1, alu_dst=5, alu_data=16'h1234 for one cycle. Next cycle: rf_we=1, rf_dst=5, rf_data=16'h1234, pending=16'h0020. The cycle after: rf_we=0, pending=0.
- Dual same-register write: mem (dst 3, 16'hAAAA) and alu (dst 3, 16'h5555) in the same cycle. Writes appear as AAAA then 5555 on consecutive cycles, and pending[3] stays 1 through both.
- Fill to full (DEPTH=4) with both producers valid every cycle:
  - Cycle 1: both transfer (count 0 → 2).
  - Cycle 2: count 2 → 3, because the pop frees a slot; no overflow.
  - count == 4: mem_ready=0 and alu_ready=0.
  - count == 3 with mem_valid: alu_ready=0.
- Register 0 discard: alu_valid=1, alu_dst=0, alu_data=16'hFFFF. alu_ready=1, no rf_we pulse, pending stays 0.
- Reset mid-operation: with 3 entries queued, assert rst for one cycle. Next cycle: rf_we=0, pending=0, and no queued data is ever written.
- Bypass (WB_BYPASS_EN): queue dst 7 = 16'h0001, then dst 7 = 16'h0002, with byp_reg=7. byp_hit=1 and byp_data=16'h0002 while both entries are queued. Built without the macro: byp_hit=0.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Writeback queue: merges memory and ALU results (memory older) into an in-order FIFO feeding the register file write port.
// Publishes a per-register pending-write scoreboard; optional youngest-entry bypass lookup under WB_BYPASS_EN.
module regfile_wb_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid,
   input  logic [REG_W-1:0]      mem_dst,
   input  logic [DATA_W-1:0]     mem_data,
   output logic                  mem_ready,
   input  logic                  alu_valid,
   input  logic [REG_W-1:0]      alu_dst,
   input  logic [DATA_W-1:0]     alu_data,
   output logic                  alu_ready,
   output logic                  rf_we,
   output logic [REG_W-1:0]      rf_dst,
   output logic [DATA_W-1:0]     rf_data,
   output logic [(1<<REG_W)-1:0] pending,
   input  logic [REG_W-1:0]      byp_reg,
   output logic                  byp_hit,
   output logic [DATA_W-1:0]     byp_data
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [REG_W-1:0]  dst_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     mem_slot, alu_slot;
   logic              mem_push, alu_push, pop;

   // Readies look only at start-of-cycle occupancy so they never depend on their own valid.
   assign mem_ready = !rst && (count_q <= FULL - CW'(1));
   assign alu_ready = !rst && ((count_q <= FULL - CW'(2)) ||
                               ((count_q == FULL - CW'(1)) && !mem_valid));

   // Register 0 results complete the handshake but are dropped.
   assign mem_push = mem_valid && mem_ready && (mem_dst != '0);
   assign alu_push = alu_valid && alu_ready && (alu_dst != '0);
   assign pop      = (count_q != '0);

   always_comb begin
      mem_slot = tail_q;
      alu_slot = mem_push ? tail_q + PW'(1) : tail_q;
      tail_d   = tail_q + PW'(mem_push) + PW'(alu_push);
      head_d   = head_q + PW'(pop);
      count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      vld_d    = vld_q;
      if (pop)      vld_d[head_q]   = 1'b0;
      if (mem_push) vld_d[mem_slot] = 1'b1;
      if (alu_push) vld_d[alu_slot] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_push) begin
         dst_q[mem_slot]  <= mem_dst;
         data_q[mem_slot] <= mem_data;
      end
      if (alu_push) begin
         dst_q[alu_slot]  <= alu_dst;
         data_q[alu_slot] <= alu_data;
      end
   end

   // The head retires every cycle; suppressed under reset so flushed entries never reach the file.
   assign rf_we   = pop && !rst;
   assign rf_dst  = rf_we ? dst_q[head_q]  : '0;
   assign rf_data = rf_we ? data_q[head_q] : '0;

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i]) pending[dst_q[i]] = 1'b1;
      end
      pending[0] = 1'b0;
   end

`ifdef WB_BYPASS_EN
   // Walk oldest to youngest so the last match wins.
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (vld_q[PW'(head_q + PW'(k))] && (dst_q[PW'(head_q + PW'(k))] == byp_reg) &&
             (byp_reg != '0)) begin
            byp_hit  = 1'b1;
            byp_data = data_q[PW'(head_q + PW'(k))];
         end
      end
   end
`else
   logic byp_unused;
   assign byp_unused = ^byp_reg;
   assign byp_hit    = 1'b0;
   assign byp_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: a DEPTH=4 instance for most steps, a DEPTH=2 instance to reach full.
module tb_regfile_wb_queue;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, alu_valid;
   logic [3:0]  mem_dst, alu_dst, byp_reg;
   logic [15:0] mem_data, alu_data;

   logic        mem_ready, alu_ready, rf_we, byp_hit;
   logic [3:0]  rf_dst;
   logic [15:0] rf_data, byp_data, pending;

   logic        mem_ready2, alu_ready2, rf_we2, byp_hit2;
   logic [3:0]  rf_dst2;
   logic [15:0] rf_data2, byp_data2, pending2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_wb_queue #(.DEPTH(4), .DATA_W(16), .REG_W(4)) u_dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready),
      .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
      .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data), .pending(pending),
      .byp_reg(byp_reg), .byp_hit(byp_hit), .byp_data(byp_data)
   );

   regfile_wb_queue #(.DEPTH(2), .DATA_W(16), .REG_W(4)) u_dut2 (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready2),
      .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready2),
      .rf_we(rf_we2), .rf_dst(rf_dst2), .rf_data(rf_data2), .pending(pending2),
      .byp_reg(byp_reg), .byp_hit(byp_hit2), .byp_data(byp_data2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                        input logic av, input logic [3:0] ad, input logic [15:0] adat);
      mem_valid = mv; mem_dst = md; mem_data = mdat;
      alu_valid = av; alu_dst = ad; alu_data = adat;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
   endtask

   initial begin
      rst = 1'b1; byp_reg = 4'd0;
      idle();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_ready", 32'(mem_ready), 32'h0);
      chk("rst_alu_ready", 32'(alu_ready), 32'h0);
      chk("rst_rf_we",     32'(rf_we),     32'h0);
      chk("rst_rf_dst",    32'(rf_dst),    32'h0);
      chk("rst_rf_data",   32'(rf_data),   32'h0);
      chk("rst_pending",   32'(pending),   32'h0);
      chk("rst_byp_hit",   32'(byp_hit),   32'h0);
      chk("rst_byp_data",  32'(byp_data),  32'h0);
      rst = 1'b0;
      #1;
      chk("post_rst_mem_ready", 32'(mem_ready), 32'h1);
      chk("post_rst_alu_ready", 32'(alu_ready), 32'h1);

      // single ALU write
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h1234);
      #1 chk("t1_alu_ready", 32'(alu_ready), 32'h1);
      @(negedge clk); idle(); #1;
      chk("t1_rf_we",   32'(rf_we),   32'h1);
      chk("t1_rf_dst",  32'(rf_dst),  32'h5);
      chk("t1_rf_data", 32'(rf_data), 32'h1234);
      chk("t1_pending", 32'(pending), 32'h0020);
      @(negedge clk); #1;
      chk("t1_rf_we_off",   32'(rf_we),   32'h0);
      chk("t1_pending_off", 32'(pending), 32'h0);

      // dual same-register write
      drive(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd3, 16'h5555);
      #1;
      chk("t2_mem_ready", 32'(mem_ready), 32'h1);
      chk("t2_alu_ready", 32'(alu_ready), 32'h1);
      @(negedge clk); idle(); #1;
      chk("t2_w1_dst",  32'(rf_dst),  32'h3);
      chk("t2_w1_data", 32'(rf_data), 32'hAAAA);
      chk("t2_w1_pend", 32'(pending), 32'h0008);
      @(negedge clk); #1;
      chk("t2_w2_we",   32'(rf_we),   32'h1);
      chk("t2_w2_data", 32'(rf_data), 32'h5555);
      chk("t2_w2_pend", 32'(pending), 32'h0008);
      @(negedge clk); #1;
      chk("t2_done_we",   32'(rf_we),   32'h0);
      chk("t2_done_pend", 32'(pending), 32'h0);

      // fill with both producers valid every cycle
      drive(1'b1, 4'd1, 16'h1001, 1'b1, 4'd2, 16'h2001);
      #1;
      chk("t3_c1_mem_ready", 32'(mem_ready), 32'h1);
      chk("t3_c1_alu_ready", 32'(alu_ready), 32'h1);
      @(negedge clk); drive(1'b1, 4'd1, 16'h1002, 1'b1, 4'd2, 16'h2002); #1;
      chk("t3_c2_rf_data",   32'(rf_data),   32'h1001);
      chk("t3_c2_mem_ready", 32'(mem_ready), 32'h1);
      chk("t3_c2_alu_ready", 32'(alu_ready), 32'h1);
      chk("t3_c2_pending",   32'(pending),   32'h0006);
      @(negedge clk); drive(1'b1, 4'd1, 16'h1003, 1'b1, 4'd2, 16'h2003); #1;
      chk("t3_c3_rf_data",   32'(rf_data),   32'h2001);
      chk("t3_c3_mem_ready", 32'(mem_ready), 32'h1);
      chk("t3_c3_alu_ready", 32'(alu_ready), 32'h0);
      @(negedge clk); drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 16'h2004); #1;
      chk("t3_c4_rf_data",   32'(rf_data),   32'h1002);
      chk("t3_c4_alu_ready", 32'(alu_ready), 32'h1);
      @(negedge clk); idle(); #1;
      chk("t3_d1_data", 32'(rf_data), 32'h2002);
      @(negedge clk); #1;
      chk("t3_d2_data", 32'(rf_data), 32'h1003);
      @(negedge clk); #1;
      chk("t3_d3_data", 32'(rf_data), 32'h2004);
      @(negedge clk); #1;
      chk("t3_empty_we", 32'(rf_we), 32'h0);

      // register 0 discard
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hFFFF);
      #1 chk("t4_alu_ready", 32'(alu_ready), 32'h1);
      @(negedge clk); idle(); #1;
      chk("t4_rf_we",   32'(rf_we),   32'h0);
      chk("t4_pending", 32'(pending), 32'h0);

      // reset mid-operation with three entries queued
      drive(1'b1, 4'd4, 16'h4441, 1'b1, 4'd6, 16'h6661);
      @(negedge clk); drive(1'b1, 4'd8, 16'h8882, 1'b1, 4'd9, 16'h9992);
      @(negedge clk); idle(); #1;
      chk("t5_pending_pre", 32'(pending), 32'h0340);
      chk("t5_head_pre",    32'(rf_data), 32'h6661);
      rst = 1'b1; #1;
      chk("t5_rst_mem_ready", 32'(mem_ready), 32'h0);
      chk("t5_rst_alu_ready", 32'(alu_ready), 32'h0);
      @(negedge clk); rst = 1'b0; #1;
      chk("t5_post_we",        32'(rf_we),     32'h0);
      chk("t5_post_pending",   32'(pending),   32'h0);
      chk("t5_post_mem_ready", 32'(mem_ready), 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("t5_no_flushed_write", 32'(rf_we), 32'h0);
      end

      // full on the two-entry queue
      drive(1'b1, 4'd1, 16'hA001, 1'b1, 4'd2, 16'hA002);
      #1;
      chk("t6_c1_mem_ready2", 32'(mem_ready2), 32'h1);
      chk("t6_c1_alu_ready2", 32'(alu_ready2), 32'h1);
      @(negedge clk); drive(1'b1, 4'd3, 16'hA003, 1'b1, 4'd4, 16'hA004); #1;
      chk("t6_full_mem_ready2", 32'(mem_ready2), 32'h0);
      chk("t6_full_alu_ready2", 32'(alu_ready2), 32'h0);
      chk("t6_full_rf_data2",   32'(rf_data2),   32'hA001);
      chk("t6_full_pending2",   32'(pending2),   32'h0006);
      @(negedge clk); #1;
      chk("t6_rec_mem_ready2", 32'(mem_ready2), 32'h1);
      chk("t6_rec_alu_ready2", 32'(alu_ready2), 32'h0);
      chk("t6_rec_rf_data2",   32'(rf_data2),   32'hA002);
      idle(); #1;
      chk("t6_rec_alu_ready2_nomem", 32'(alu_ready2), 32'h1);
      repeat (6) @(negedge clk);
      #1;
      chk("t6_drained_we",  32'(rf_we),  32'h0);
      chk("t6_drained_we2", 32'(rf_we2), 32'h0);

      // bypass lookup
      byp_reg = 4'd7;
      drive(1'b1, 4'd7, 16'h0001, 1'b1, 4'd7, 16'h0002);
      @(negedge clk); idle(); #1;
      chk("t7_pending",  32'(pending),  32'h0080);
      chk("t7_byp_hit",  32'(byp_hit),  32'(BYP));
      chk("t7_byp_data", 32'(byp_data), BYP ? 32'h0002 : 32'h0);
      byp_reg = 4'd3; #1;
      chk("t7_miss_hit",  32'(byp_hit),  32'h0);
      chk("t7_miss_data", 32'(byp_data), 32'h0);
      @(negedge clk); byp_reg = 4'd7; #1;
      chk("t7_one_hit",  32'(byp_hit),  32'(BYP));
      chk("t7_one_data", 32'(byp_data), BYP ? 32'h0002 : 32'h0);
      byp_reg = 4'd0; #1;
      chk("t7_reg0_hit", 32'(byp_hit), 32'h0);
      repeat (2) @(negedge clk);
      #1;
      chk("t7_final_we", 32'(rf_we), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
